intirvx_wb_arbiter: RTL and testbench

- Parametrised N-source write-back stage for the IntiRVX CPU, sitting between the execute-side result producers (ALU, MEM, CSR, future MUL/DIV) and the register manager.
- Arbitrates among NUM_SRC valid/ready result channels using fixed-priority or round-robin selection.
- Registers the winning write in a one-entry output stage with backpressure, suppresses writes to x0, and converts source exceptions into a held exception report that stalls retirement until acknowledged.

---
 rtl/intirvx_wb_arbiter_pkg.sv | 33 +++
 rtl/intirvx_rr_arbiter.sv | 43 ++++
 rtl/intirvx_wb_arbiter.sv | 125 ++++++++++++
 tb/tb_intirvx_wb_arbiter.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/intirvx_wb_arbiter_pkg.sv
// Shared types and constants for the IntiRVX write-back arbiter.
// Provides the wb_bus payload, exception report and arbiter modes.
package intirvx_wb_arbiter_pkg;

  localparam int CPU_XLEN  = 32;
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;
  localparam int RD_W      = 5;
  localparam int SRC_IDX_W = 3;

  typedef struct packed {
    logic [CPU_XLEN-1:0] data;
    logic [RD_W-1:0]     adr;
  } wb_bus;

  typedef struct packed {
    logic                 valid;
    logic [SRC_IDX_W-1:0] src;
  } wb_exc_t;

  typedef enum logic {
    RUN      = 1'b0,
    EXC_WAIT = 1'b1
  } wb_state_e;

  function automatic int wrap_inc(
    input int v,
    input int n
  );
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/intirvx_rr_arbiter.sv
// One-hot arbiter, fixed priority or round-robin by MODE.
// Ports: clk, rst, req[N], advance (grant taken), gnt[N] one-hot.
module intirvx_rr_arbiter
  import intirvx_wb_arbiter_pkg::*;
#(
  parameter int N    = 3,
  parameter int MODE = ARB_FIXED
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int PW = $clog2(N);

  logic [PW-1:0] ptr;
  int            base;
  int            hit;

  assign base = (MODE == ARB_RR) ? int'(ptr) : 0;

  // First requester at or after base, wrapping.
  always_comb begin
    gnt = '0;
    hit = -1;
    for (int k = 0; k < N; k++) begin
      if (hit < 0 && req[(base + k) % N])
        hit = (base + k) % N;
    end
    if (hit >= 0)
      gnt[hit] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= '0;
    else if (MODE == ARB_RR && advance && hit >= 0)
      ptr <= PW'(wrap_inc(hit, N));
  end

endmodule

// File: rtl/intirvx_wb_arbiter.sv
// N-source write-back stage: arbitrate, register, drop x0, hold exc.
// Ports: src_* channels in, wb/wb_valid/wb_ready out, exc_*, wb_count.
module intirvx_wb_arbiter
  import intirvx_wb_arbiter_pkg::*;
#(
  parameter int XLEN     = CPU_XLEN,
  parameter int NUM_SRC  = 3,
  parameter int ARB_MODE = ARB_FIXED
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SRC-1:0]         src_valid,
  output logic [NUM_SRC-1:0]         src_ready,
  input  logic [NUM_SRC*XLEN-1:0]    src_data,
  input  logic [NUM_SRC*RD_W-1:0]    src_rd,
  input  logic [NUM_SRC-1:0]         src_exc,
  output wb_bus                      wb,
  output logic                       wb_valid,
  input  logic                       wb_ready,
  output logic                       exc_valid,
  output logic [$clog2(NUM_SRC)-1:0] exc_src,
  input  logic                       exc_ack,
  output logic [31:0]                wb_count
);

  localparam int SW = $clog2(NUM_SRC);

  wb_state_e         state;
  wb_state_e         state_d;
  logic [SW-1:0]     exc_src_d;
  logic              free;
  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] gnt;
  logic              take;
  int                gi;
  logic [XLEN-1:0]   g_data;
  logic [RD_W-1:0]   g_rd;
  logic              g_exc;
  logic              do_wr;

  assign free = !wb_valid || wb_ready;

  // rst gate keeps src_ready low while reset is held.
  assign req = (state == RUN && free && !rst)
             ? src_valid : '0;

  intirvx_rr_arbiter #(
    .N    (NUM_SRC),
    .MODE (ARB_MODE)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (take),
    .gnt     (gnt)
  );

  assign take      = |gnt;
  assign src_ready = gnt;

  always_comb begin
    gi = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gnt[i])
        gi = i;
    end
  end

  assign g_data = src_data[gi*XLEN +: XLEN];
  assign g_rd   = src_rd[gi*RD_W +: RD_W];
  assign g_exc  = src_exc[gi];
  assign do_wr  = take && !g_exc && (g_rd != '0);

  assign exc_valid = (state == EXC_WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      exc_src <= '0;
    end else begin
      state   <= state_d;
      exc_src <= exc_src_d;
    end
  end

  always_comb begin
    state_d   = state;
    exc_src_d = exc_src;
    unique case (state)
      RUN: begin
        if (take && g_exc) begin
          state_d   = EXC_WAIT;
          exc_src_d = SW'(gi);
        end
      end
      EXC_WAIT: begin
        if (exc_ack)
          state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // New write wins over drain so back-to-back keeps 1 write/cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb       <= '0;
      wb_valid <= 1'b0;
    end else if (do_wr) begin
      wb.data  <= g_data;
      wb.adr   <= g_rd;
      wb_valid <= 1'b1;
    end else if (wb_ready) begin
      wb_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wb_count <= '0;
    else if (wb_valid && wb_ready)
      wb_count <= wb_count + 32'd1;
  end

endmodule

// File: tb/tb_intirvx_wb_arbiter.sv
// Bench for intirvx_wb_arbiter: fixed and RR instances, shared inputs.
// Directed scenarios plus random stimulus against a reference model.
module tb_intirvx_wb_arbiter;
  import intirvx_wb_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  src_valid;
  logic [95:0] src_data;
  logic [14:0] src_rd;
  logic [2:0]  src_exc;
  logic        wb_ready;
  logic        exc_ack;

  logic [2:0]  f_ready, r_ready;
  wb_bus       f_wb, r_wb;
  logic        f_wbv, r_wbv;
  logic        f_excv, r_excv;
  logic [1:0]  f_excs, r_excs;
  logic [31:0] f_cnt, r_cnt;

  logic [2:0]  a_ready [2];
  wb_bus       a_wb    [2];
  logic        a_wbv   [2];
  logic        a_excv  [2];
  logic [1:0]  a_excs  [2];
  logic [31:0] a_cnt   [2];

  assign a_ready[0] = f_ready;
  assign a_ready[1] = r_ready;
  assign a_wb[0]    = f_wb;
  assign a_wb[1]    = r_wb;
  assign a_wbv[0]   = f_wbv;
  assign a_wbv[1]   = r_wbv;
  assign a_excv[0]  = f_excv;
  assign a_excv[1]  = r_excv;
  assign a_excs[0]  = f_excs;
  assign a_excs[1]  = r_excs;
  assign a_cnt[0]   = f_cnt;
  assign a_cnt[1]   = r_cnt;

  always #5 clk = ~clk;

  intirvx_wb_arbiter #(
    .XLEN(32), .NUM_SRC(3), .ARB_MODE(ARB_FIXED)
  ) u_fix (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_ready(f_ready),
    .src_data(src_data), .src_rd(src_rd),
    .src_exc(src_exc),
    .wb(f_wb), .wb_valid(f_wbv), .wb_ready(wb_ready),
    .exc_valid(f_excv), .exc_src(f_excs),
    .exc_ack(exc_ack), .wb_count(f_cnt)
  );

  intirvx_wb_arbiter #(
    .XLEN(32), .NUM_SRC(3), .ARB_MODE(ARB_RR)
  ) u_rr (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_ready(r_ready),
    .src_data(src_data), .src_rd(src_rd),
    .src_exc(src_exc),
    .wb(r_wb), .wb_valid(r_wbv), .wb_ready(wb_ready),
    .exc_valid(r_excv), .exc_src(r_excs),
    .exc_ack(exc_ack), .wb_count(r_cnt)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state per mode: 0 = fixed, 1 = round-robin.
  bit          m_wbv  [2];
  logic [31:0] m_data [2];
  logic [4:0]  m_adr  [2];
  bit          m_excv [2];
  int          m_excs [2];
  int unsigned m_cnt  [2];
  int          m_ptr  [2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_wbv[m]  = 0;
      m_data[m] = '0;
      m_adr[m]  = '0;
      m_excv[m] = 0;
      m_excs[m] = 0;
      m_cnt[m]  = 0;
      m_ptr[m]  = 0;
    end
  endtask

  function automatic int exp_gnt(int m);
    if (rst || m_excv[m]) return -1;
    if (m_wbv[m] && !wb_ready) return -1;
    for (int k = 0; k < 3; k++) begin
      int i;
      i = (m == 1) ? (m_ptr[m] + k) % 3 : k;
      if (src_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [2:0] exp_ready(int m);
    logic [2:0] v;
    int g;
    v = '0;
    g = exp_gnt(m);
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      int g;
      g = exp_gnt(m);
      if (m_wbv[m] && wb_ready) m_cnt[m]++;
      if (wb_ready) m_wbv[m] = 0;
      if (m_excv[m] && exc_ack) m_excv[m] = 0;
      if (g >= 0) begin
        if (src_exc[g]) begin
          m_excv[m] = 1;
          m_excs[m] = g;
        end else if (src_rd[g*5 +: 5] != 0) begin
          m_wbv[m]  = 1;
          m_data[m] = src_data[g*32 +: 32];
          m_adr[m]  = src_rd[g*5 +: 5];
        end
        if (m == 1) m_ptr[m] = (g + 1) % 3;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_src(int i, logic [31:0] d, logic [4:0] r);
    src_data[i*32 +: 32] = d;
    src_rd[i*5 +: 5]     = r;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    src_valid = 3'b111;
    src_data = '0;
    src_rd = '0;
    src_exc = '0;
    wb_ready = 1'b0;
    exc_ack = 1'b0;
    model_reset();
    #12;
    for (int m = 0; m < 2; m++) begin
      n_chk++;
      if (a_ready[m] !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_ready m%0d got %b want 000", m, a_ready[m]);
      end
      n_chk++;
      if (a_wbv[m] !== 1'b0 || a_wb[m] !== '0) begin
        n_fail++;
        $display("FAIL reset_wb m%0d got v=%b %h want 0", m, a_wbv[m], a_wb[m]);
      end
      n_chk++;
      if (a_excv[m] !== 1'b0 || a_excs[m] !== 2'd0 || a_cnt[m] !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_exc m%0d got %b %0d %0d want 0", m, a_excv[m], a_excs[m], a_cnt[m]);
      end
    end
    rst = 1'b0;
    src_valid = '0;
  endtask

  task automatic test_arbitration();
    for (int i = 0; i < 3; i++) set_src(i, 32'h100 + i, 5'(i + 1));
    src_valid = 3'b111;
    wb_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      n_chk++;
      if (f_ready !== 3'b001) begin
        n_fail++;
        $display("FAIL fix_grant k%0d got %b want 001", k, f_ready);
      end
      n_chk++;
      if (r_ready !== 3'(1 << (k % 3))) begin
        n_fail++;
        $display("FAIL rr_grant k%0d got %b want %b", k, r_ready, 3'(1 << (k % 3)));
      end
      tick();
      n_chk++;
      if (f_wbv !== 1'b1 || f_wb.adr !== 5'd1) begin
        n_fail++;
        $display("FAIL fix_adr k%0d got v=%b adr=%0d want 1/1", k, f_wbv, f_wb.adr);
      end
      n_chk++;
      if (r_wbv !== 1'b1 || r_wb.adr !== 5'(k % 3 + 1) || r_wb.data !== 32'h100 + k % 3) begin
        n_fail++;
        $display("FAIL rr_wb k%0d got v=%b adr=%0d d=%h want adr=%0d", k, r_wbv, r_wb.adr, r_wb.data, k % 3 + 1);
      end
    end
    src_valid = '0;
    #1;
    n_chk++;
    if (f_ready !== 3'b000 || r_ready !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_ready got %b %b want 000", f_ready, r_ready);
    end
    tick();
    for (int m = 0; m < 2; m++) begin
      n_chk++;
      if (a_wbv[m] !== 1'b0 || a_cnt[m] !== 32'd6) begin
        n_fail++;
        $display("FAIL count6 m%0d got v=%b cnt=%0d want 0/6", m, a_wbv[m], a_cnt[m]);
      end
    end
  endtask

  task automatic test_backpressure();
    set_src(0, 32'hDEADBEEF, 5'd5);
    set_src(1, 32'h77, 5'd7);
    src_valid = 3'b001;
    wb_ready = 1'b0;
    tick();
    src_valid = 3'b010;
    for (int k = 0; k < 4; k++) begin
      #1;
      for (int m = 0; m < 2; m++) begin
        n_chk++;
        if (a_wbv[m] !== 1'b1 || a_wb[m].data !== 32'hDEADBEEF ||
            a_wb[m].adr !== 5'd5 || a_ready[m] !== 3'b000) begin
          n_fail++;
          $display("FAIL bp_hold m%0d k%0d got v=%b %h/%0d rdy=%b", m, k, a_wbv[m], a_wb[m].data, a_wb[m].adr, a_ready[m]);
        end
      end
      tick();
    end
    src_valid = '0;
    wb_ready = 1'b1;
    tick();
    for (int m = 0; m < 2; m++) begin
      n_chk++;
      if (a_wbv[m] !== 1'b0 || a_cnt[m] !== 32'd7) begin
        n_fail++;
        $display("FAIL bp_drain m%0d got v=%b cnt=%0d want 0/7", m, a_wbv[m], a_cnt[m]);
      end
    end
  endtask

  task automatic test_x0();
    set_src(1, 32'h1234, 5'd0);
    src_valid = 3'b010;
    wb_ready = 1'b1;
    #1;
    for (int m = 0; m < 2; m++) begin
      n_chk++;
      if (a_ready[m] !== 3'b010) begin
        n_fail++;
        $display("FAIL x0_ready m%0d got %b want 010", m, a_ready[m]);
      end
    end
    tick();
    src_valid = '0;
    for (int m = 0; m < 2; m++) begin
      n_chk++;
      if (a_wbv[m] !== 1'b0 || a_cnt[m] !== 32'd7) begin
        n_fail++;
        $display("FAIL x0_nowb m%0d got v=%b cnt=%0d want 0/7", m, a_wbv[m], a_cnt[m]);
      end
    end
  endtask

  task automatic test_exception();
    for (int i = 0; i < 3; i++) set_src(i, 32'h200 + i, 5'(i + 1));
    src_valid = 3'b111;
    src_exc = 3'b100;
    wb_ready = 1'b1;
    #1;
    n_chk++;
    if (f_ready !== 3'b001) begin
      n_fail++;
      $display("FAIL exc_first got %b want 001", f_ready);
    end
    tick();
    n_chk++;
    if (r_excv !== 1'b1 || r_excs !== 2'd2) begin
      n_fail++;
      $display("FAIL rr_exc got %b/%0d want 1/2", r_excv, r_excs);
    end
    src_valid = 3'b100;
    #1;
    n_chk++;
    if (f_ready !== 3'b100) begin
      n_fail++;
      $display("FAIL exc_grant got %b want 100", f_ready);
    end
    tick();
    n_chk++;
    if (f_excv !== 1'b1 || f_excs !== 2'd2 || f_wbv !== 1'b0) begin
      n_fail++;
      $display("FAIL exc_set got %b/%0d wbv=%b want 1/2/0", f_excv, f_excs, f_wbv);
    end
    src_valid = 3'b010;
    src_exc = '0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_chk++;
      if (f_ready !== 3'b000 || f_excv !== 1'b1) begin
        n_fail++;
        $display("FAIL exc_stall k%0d got rdy=%b excv=%b", k, f_ready, f_excv);
      end
      tick();
    end
    exc_ack = 1'b1;
    tick();
    exc_ack = 1'b0;
    #1;
    n_chk++;
    if (f_excv !== 1'b0 || f_ready !== 3'b010) begin
      n_fail++;
      $display("FAIL exc_ack got excv=%b rdy=%b want 0/010", f_excv, f_ready);
    end
    tick();
  endtask

  task automatic test_async_reset();
    set_src(1, 32'h99, 5'd9);
    src_valid = 3'b010;
    wb_ready = 1'b0;
    #1;
    n_chk++;
    if (f_wbv !== 1'b1 || r_wbv !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_rst got %b %b want 1 1", f_wbv, r_wbv);
    end
    #1 rst = 1'b1;
    #1;
    for (int m = 0; m < 2; m++) begin
      n_chk++;
      if (a_wbv[m] !== 1'b0 || a_cnt[m] !== 32'd0 || a_ready[m] !== 3'b000) begin
        n_fail++;
        $display("FAIL rst_wb m%0d got v=%b cnt=%0d rdy=%b", m, a_wbv[m], a_cnt[m], a_ready[m]);
      end
    end
    rst = 1'b0;
    model_reset();
    src_valid = 3'b111;
    src_exc = 3'b001;
    #1;
    n_chk++;
    if (r_ready !== 3'b001) begin
      n_fail++;
      $display("FAIL rr_restart got %b want 001", r_ready);
    end
    tick();
    for (int m = 0; m < 2; m++) begin
      n_chk++;
      if (a_excv[m] !== 1'b1) begin
        n_fail++;
        $display("FAIL pre_rst_exc m%0d got %b want 1", m, a_excv[m]);
      end
    end
    #2 rst = 1'b1;
    #1;
    for (int m = 0; m < 2; m++) begin
      n_chk++;
      if (a_excv[m] !== 1'b0 || a_excs[m] !== 2'd0 || a_ready[m] !== 3'b000) begin
        n_fail++;
        $display("FAIL rst_exc m%0d got %b/%0d rdy=%b", m, a_excv[m], a_excs[m], a_ready[m]);
      end
    end
    rst = 1'b0;
    model_reset();
    src_valid = '0;
    src_exc = '0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) begin
        set_src(i, $urandom, ($urandom % 4 == 0) ? 5'd0 : 5'($urandom));
        src_exc[i] = ($urandom % 8 == 0);
      end
      src_valid = 3'($urandom);
      wb_ready = ($urandom % 4 != 0);
      exc_ack = ($urandom % 3 == 0);
      #1;
      for (int m = 0; m < 2; m++) begin
        n_chk++;
        if (a_ready[m] !== exp_ready(m)) begin
          n_fail++;
          $display("FAIL rnd_ready m%0d c%0d got %b want %b", m, c, a_ready[m], exp_ready(m));
        end
        n_chk++;
        if (a_wbv[m] !== m_wbv[m] ||
            (m_wbv[m] && (a_wb[m].data !== m_data[m] || a_wb[m].adr !== m_adr[m]))) begin
          n_fail++;
          $display("FAIL rnd_wb m%0d c%0d got %b %h/%0d want %b %h/%0d", m, c, a_wbv[m], a_wb[m].data, a_wb[m].adr, m_wbv[m], m_data[m], m_adr[m]);
        end
        n_chk++;
        if (a_excv[m] !== m_excv[m] || (m_excv[m] && a_excs[m] !== 2'(m_excs[m]))) begin
          n_fail++;
          $display("FAIL rnd_exc m%0d c%0d got %b/%0d want %b/%0d", m, c, a_excv[m], a_excs[m], m_excv[m], m_excs[m]);
        end
        n_chk++;
        if (a_cnt[m] !== m_cnt[m]) begin
          n_fail++;
          $display("FAIL rnd_cnt m%0d c%0d got %0d want %0d", m, c, a_cnt[m], m_cnt[m]);
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_backpressure();
    test_x0();
    test_exception();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
